// File: rtl/hc_core.sv
// rtl/hc_core.sv - parametrised HC stack-machine CPU core with external fetch and data ports
module hc_core #(
   parameter int DATA_W      = 8,
   parameter int STACK_DEPTH = 3,
   parameter int ADDR_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          imem_req,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic [7:0]                    imem_rdata,
   input  logic                          imem_ack,
   output logic                          dmem_req,
   output logic                          dmem_we,
   output logic [ADDR_W-1:0]             dmem_addr,
   output logic [DATA_W-1:0]             dmem_wdata,
   input  logic [DATA_W-1:0]             dmem_rdata,
   input  logic                          dmem_ack,
   output logic [ADDR_W-1:0]             pc_out,
   output logic [DATA_W*STACK_DEPTH-1:0] stack_out,
   output logic [1:0]                    flags_out,
   output logic                          retire
);

   typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_MEM} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [7:0]          ir_q, ir_d;
   logic [DATA_W-1:0]   stk_q [STACK_DEPTH];
   logic [DATA_W-1:0]   stk_d [STACK_DEPTH];
   logic                c_q, c_d;
   logic                z_q, z_d;
   logic                c_pend_q, c_pend_d;
   logic                imem_req_q, imem_req_d;
   logic                dmem_req_q, dmem_req_d;
   logic                dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic                retire_q, retire_d;

   logic [3:0]          op;
   logic [3:0]          imm;
   logic [2:0]          sel;
   logic [2:0]          cond;
   logic [DATA_W-1:0]   a;
   logic [DATA_W-1:0]   b;
   logic [ADDR_W-1:0]   ab_addr;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic                taken;
   logic                do_push;
   logic [DATA_W-1:0]   push_val;

   assign op      = ir_q[7:4];
   assign imm     = ir_q[3:0];
   assign sel     = ir_q[6:4];
   assign cond    = ir_q[2:0];
   assign a       = stk_q[0];
   assign b       = stk_q[1];
   assign ab_addr = ADDR_W'({b, a});
   assign r_addr  = ADDR_W'(imm);
   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} - {1'b0, b};

   // ALU for the store group; carry is only meaningful for ADD and SUB
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (sel)
         3'b001: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];   end
         3'b010: begin alu_res = diff[DATA_W-1:0]; alu_c = ~diff[DATA_W]; end
         3'b011: alu_res = a & b;
         3'b100: alu_res = a | b;
         3'b101: alu_res = a ^ b;
         3'b110: alu_res = a;
         3'b111: alu_res = b;
         default: alu_res = '0;
      endcase
   end

   // jump condition from the committed flags
   always_comb begin
      case (cond)
         3'b000:  taken = 1'b1;
         3'b010:  taken = c_q;
         3'b011:  taken = ~c_q;
         3'b100:  taken = z_q;
         3'b101:  taken = ~z_q;
         default: taken = 1'b0;
      endcase
   end

   // next-state logic for the fetch/exec/mem sequencer and all architectural state
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      c_d          = c_q;
      z_d          = z_q;
      c_pend_d     = c_pend_q;
      imem_req_d   = imem_req_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      retire_d     = 1'b0;
      do_push      = 1'b0;
      push_val     = '0;
      for (int k = 0; k < STACK_DEPTH; k++) stk_d[k] = stk_q[k];

      case (state_q)
         S_INIT: begin
            state_d    = S_FETCH;
            imem_req_d = 1'b1;
         end
         S_FETCH: begin
            if (imem_ack) begin
               ir_d       = imem_rdata;
               imem_req_d = 1'b0;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!op[3]) begin
               // SC (sel 000) or ALU store; operands latched so they stay stable during MEM
               dmem_req_d   = 1'b1;
               dmem_we_d    = 1'b1;
               dmem_addr_d  = (sel == 3'b000) ? ab_addr : r_addr;
               dmem_wdata_d = (sel == 3'b000) ? stk_q[2] : alu_res;
               c_pend_d     = alu_c;
               state_d      = S_MEM;
            end else if (op[3:1] == 3'b100) begin
               dmem_req_d  = 1'b1;
               dmem_we_d   = 1'b0;
               dmem_addr_d = op[0] ? r_addr : ab_addr;
               state_d     = S_MEM;
            end else begin
               pc_d       = pc_q + ADDR_W'(1);
               retire_d   = 1'b1;
               imem_req_d = 1'b1;
               state_d    = S_FETCH;
               if (op == 4'b1010) begin
                  do_push  = 1'b1;
                  push_val = {a[DATA_W-1:4], imm};
               end else if (op[3:1] == 3'b110) begin
                  stk_d[0] = {a[DATA_W-5:0], imm};
               end else if (op[3:1] == 3'b111) begin
                  if (taken) pc_d = ab_addr;
               end
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               pc_d       = pc_q + ADDR_W'(1);
               retire_d   = 1'b1;
               imem_req_d = 1'b1;
               state_d    = S_FETCH;
               if (dmem_we_q) begin
                  z_d = (dmem_wdata_q == '0);
                  if (sel == 3'b001 || sel == 3'b010) c_d = c_pend_q;
               end else begin
                  do_push  = 1'b1;
                  push_val = dmem_rdata;
               end
            end
         end
         default: state_d = S_INIT;
      endcase

      if (do_push) begin
         for (int k = STACK_DEPTH - 1; k > 0; k--) stk_d[k] = stk_q[k-1];
         stk_d[0] = push_val;
      end
   end

   // state registers with asynchronous abort on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         pc_q         <= '0;
         ir_q         <= '0;
         c_q          <= 1'b0;
         z_q          <= 1'b0;
         c_pend_q     <= 1'b0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         retire_q     <= 1'b0;
         for (int k = 0; k < STACK_DEPTH; k++) stk_q[k] <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         c_q          <= c_d;
         z_q          <= z_d;
         c_pend_q     <= c_pend_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         retire_q     <= retire_d;
         for (int k = 0; k < STACK_DEPTH; k++) stk_q[k] <= stk_d[k];
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign pc_out     = pc_q;
   assign flags_out  = {c_q, z_q};
   assign retire     = retire_q;

   for (genvar g = 0; g < STACK_DEPTH; g++) begin : g_stack_out
      assign stack_out[g*DATA_W +: DATA_W] = stk_q[g];
   end

endmodule

// File: tb/tb_hc_core.sv
// tb/tb_hc_core.sv - table-driven bench for hc_core
module tb_hc_core;

   logic        clk = 1'b0;
   logic        rst, rst16;
   logic [7:0]  cur_instr, cur16;
   logic        iack, dack, dack16;
   logic [7:0]  drd;

   logic        imem_req, dmem_req, dmem_we, retire;
   logic [15:0] imem_addr, dmem_addr, pc_out;
   logic [7:0]  dmem_wdata;
   logic [23:0] stack_out;
   logic [1:0]  flags_out;

   logic        imem_req16, dmem_req16, dmem_we16, retire16;
   logic [15:0] imem_addr16, dmem_addr16, pc16, dmem_wdata16;
   logic [79:0] stack16;
   logic [1:0]  flags16;

   always #5 clk = ~clk;

   hc_core dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(cur_instr), .imem_ack(iack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(drd), .dmem_ack(dack),
      .pc_out(pc_out), .stack_out(stack_out), .flags_out(flags_out), .retire(retire)
   );

   hc_core #(.DATA_W(16), .STACK_DEPTH(5), .ADDR_W(16)) dut16 (
      .clk(clk), .rst(rst16),
      .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_rdata(cur16), .imem_ack(1'b1),
      .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
      .dmem_rdata(16'h0000), .dmem_ack(dack16),
      .pc_out(pc16), .stack_out(stack16), .flags_out(flags16), .retire(retire16)
   );

   typedef struct {
      logic [7:0]  instr;
      logic [7:0]  a, b, c;
      logic [1:0]  fl;
      logic [15:0] pc;
      logic        wr;
      logic [15:0] waddr;
      logic [7:0]  wdata;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;
   int   excl_bad = 0;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   int   cyc, w0, exp_cyc;

   always @(negedge clk) begin
      if (dmem_req && dmem_ack_seen() && dmem_we) begin
         wr_cnt  = wr_cnt + 1;
         wr_addr = dmem_addr;
         wr_data = dmem_wdata;
      end
      if (imem_req && dmem_req) excl_bad = excl_bad + 1;
   end

   function automatic logic dmem_ack_seen();
      return dack;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic addn(input logic [7:0] ins, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec, input logic [1:0] fl, input logic [15:0] pc);
      vec_t v;
      v.instr = ins; v.a = ea; v.b = eb; v.c = ec; v.fl = fl; v.pc = pc;
      v.wr = 1'b0; v.waddr = 16'h0; v.wdata = 8'h0;
      vq.push_back(v);
   endtask

   task automatic addw(input logic [7:0] ins, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec, input logic [1:0] fl, input logic [15:0] pc,
                       input logic [15:0] wa, input logic [7:0] wd);
      vec_t v;
      v.instr = ins; v.a = ea; v.b = eb; v.c = ec; v.fl = fl; v.pc = pc;
      v.wr = 1'b1; v.waddr = wa; v.wdata = wd;
      vq.push_back(v);
   endtask

   initial begin
      // flags column is {C,Z}
      addn(8'hA5, 8'h05, 8'h00, 8'h00, 2'd0, 16'h0001);
      addn(8'hC3, 8'h53, 8'h00, 8'h00, 2'd0, 16'h0002);
      addn(8'hA7, 8'h57, 8'h53, 8'h00, 2'd0, 16'h0003);
      addw(8'h14, 8'h57, 8'h53, 8'h00, 2'd0, 16'h0004, 16'h0004, 8'hAA);
      addw(8'h24, 8'h57, 8'h53, 8'h00, 2'd2, 16'h0005, 16'h0004, 8'h04);
      addw(8'h00, 8'h57, 8'h53, 8'h00, 2'd3, 16'h0006, 16'h5357, 8'h00);
      addn(8'hE4, 8'h57, 8'h53, 8'h00, 2'd3, 16'h5357);
      addn(8'hE5, 8'h57, 8'h53, 8'h00, 2'd3, 16'h5358);
      addn(8'hE2, 8'h57, 8'h53, 8'h00, 2'd3, 16'h5357);
      addn(8'hE3, 8'h57, 8'h53, 8'h00, 2'd3, 16'h5358);
      addn(8'hE1, 8'h57, 8'h53, 8'h00, 2'd3, 16'h5359);
      addn(8'hB0, 8'h57, 8'h53, 8'h00, 2'd3, 16'h535A);
      addw(8'h37, 8'h57, 8'h53, 8'h00, 2'd2, 16'h535B, 16'h0007, 8'h53);
      addw(8'h48, 8'h57, 8'h53, 8'h00, 2'd2, 16'h535C, 16'h0008, 8'h57);
      addw(8'h59, 8'h57, 8'h53, 8'h00, 2'd2, 16'h535D, 16'h0009, 8'h04);
      addw(8'h6A, 8'h57, 8'h53, 8'h00, 2'd2, 16'h535E, 16'h000A, 8'h57);
      addw(8'h7B, 8'h57, 8'h53, 8'h00, 2'd2, 16'h535F, 16'h000B, 8'h53);
      addn(8'h93, 8'h5A, 8'h57, 8'h53, 2'd2, 16'h5360);
      addn(8'h80, 8'h5A, 8'h5A, 8'h57, 2'd2, 16'h5361);
      addn(8'hF0, 8'h5A, 8'h5A, 8'h57, 2'd2, 16'h5A5A);
      addn(8'hC2, 8'hA2, 8'h5A, 8'h57, 2'd2, 16'h5A5B);
      addn(8'hC0, 8'h20, 8'h5A, 8'h57, 2'd2, 16'h5A5C);
      addn(8'hA0, 8'h20, 8'h20, 8'h5A, 2'd2, 16'h5A5D);
      addn(8'hCF, 8'h0F, 8'h20, 8'h5A, 2'd2, 16'h5A5E);
      addn(8'hC0, 8'hF0, 8'h20, 8'h5A, 2'd2, 16'h5A5F);
      addw(8'h14, 8'hF0, 8'h20, 8'h5A, 2'd2, 16'h5A60, 16'h0004, 8'h10);
      addn(8'hE2, 8'hF0, 8'h20, 8'h5A, 2'd2, 16'h20F0);
      addn(8'hC3, 8'h03, 8'h20, 8'h5A, 2'd2, 16'h20F1);
      addn(8'hC3, 8'h33, 8'h20, 8'h5A, 2'd2, 16'h20F2);
      addn(8'hA3, 8'h33, 8'h33, 8'h20, 2'd2, 16'h20F3);
      addw(8'h24, 8'h33, 8'h33, 8'h20, 2'd3, 16'h20F4, 16'h0004, 8'h00);
      addn(8'hE5, 8'h33, 8'h33, 8'h20, 2'd3, 16'h20F5);
      addn(8'hE4, 8'h33, 8'h33, 8'h20, 2'd3, 16'h3333);
      addn(8'hC0, 8'h30, 8'h33, 8'h20, 2'd3, 16'h3334);
      addw(8'h21, 8'h30, 8'h33, 8'h20, 2'd0, 16'h3335, 16'h0001, 8'hFD);
      addn(8'hE3, 8'h30, 8'h33, 8'h20, 2'd0, 16'h3330);
      addn(8'hE7, 8'h30, 8'h33, 8'h20, 2'd0, 16'h3331);
      addn(8'hB5, 8'h30, 8'h33, 8'h20, 2'd0, 16'h3332);
      addn(8'hCF, 8'h0F, 8'h33, 8'h20, 2'd0, 16'h3333);
      addn(8'hCF, 8'hFF, 8'h33, 8'h20, 2'd0, 16'h3334);
      addn(8'hAF, 8'hFF, 8'hFF, 8'h33, 2'd0, 16'h3335);
      addn(8'hF0, 8'hFF, 8'hFF, 8'h33, 2'd0, 16'hFFFF);
      addn(8'hB0, 8'hFF, 8'hFF, 8'h33, 2'd0, 16'h0000);
      addn(8'hE1, 8'hFF, 8'hFF, 8'h33, 2'd0, 16'h0001);

      rst = 1'b1; rst16 = 1'b1; iack = 1'b1; dack = 1'b1; dack16 = 1'b1;
      drd = 8'h5A; cur_instr = vq[0].instr; cur16 = 8'hB0;

      // reset state with imem_ack held high
      repeat (3) @(negedge clk);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_dmem_we", dmem_we, 1'b0);
      chk("rst_retire", retire, 1'b0);
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_stack", stack_out, 24'h0);
      chk("rst_flags", flags_out, 2'b00);
      rst = 1'b0;
      @(negedge clk);
      chk("first_req", imem_req, 1'b1);
      chk("first_addr", imem_addr, 16'h0000);

      // table: one instruction per record, zero-wait memories
      for (int i = 0; i < vq.size(); i++) begin
         cur_instr = vq[i].instr;
         w0 = wr_cnt;
         cyc = 0;
         do begin
            @(negedge clk);
            cyc = cyc + 1;
         end while (!retire && cyc < 20);
         if (!retire) begin
            chk($sformatf("v%0d_retire_timeout", i), 1'b0, 1'b1);
            break;
         end
         exp_cyc = (!vq[i].instr[7] || vq[i].instr[7:5] == 3'b100) ? 3 : 2;
         chk($sformatf("v%0d_latency", i), cyc, exp_cyc);
         chk($sformatf("v%0d_a", i), stack_out[7:0], vq[i].a);
         chk($sformatf("v%0d_b", i), stack_out[15:8], vq[i].b);
         chk($sformatf("v%0d_c", i), stack_out[23:16], vq[i].c);
         chk($sformatf("v%0d_flags", i), flags_out, vq[i].fl);
         chk($sformatf("v%0d_pc", i), pc_out, vq[i].pc);
         chk($sformatf("v%0d_nwr", i), wr_cnt - w0, vq[i].wr ? 1 : 0);
         if (vq[i].wr) begin
            chk($sformatf("v%0d_waddr", i), wr_addr, vq[i].waddr);
            chk($sformatf("v%0d_wdata", i), wr_data, vq[i].wdata);
         end
      end

      // LD r with data ack held low for three cycles
      drd = 8'hC6; dack = 1'b0; cur_instr = 8'h93;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc = cyc + 1;
      end while (!dmem_req && cyc < 10);
      chk("ldw_req_seen", dmem_req, 1'b1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("ldw_req_%0d", k), dmem_req, 1'b1);
         chk($sformatf("ldw_addr_%0d", k), dmem_addr, 16'h0003);
         chk($sformatf("ldw_we_%0d", k), dmem_we, 1'b0);
         chk($sformatf("ldw_a_%0d", k), stack_out[7:0], 8'hFF);
         chk($sformatf("ldw_retire_%0d", k), retire, 1'b0);
         if (k == 3) dack = 1'b1;
      end
      @(negedge clk);
      chk("ldw_done", retire, 1'b1);
      chk("ldw_a", stack_out[7:0], 8'hC6);
      chk("ldw_b", stack_out[15:8], 8'hFF);
      chk("ldw_c", stack_out[23:16], 8'hFF);
      chk("ldw_pc", pc_out, 16'h0002);

      // fetch with two wait cycles
      iack = 1'b0; cur_instr = 8'hB0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("iw_req_%0d", k), imem_req, 1'b1);
         chk($sformatf("iw_addr_%0d", k), imem_addr, 16'h0002);
         chk($sformatf("iw_retire_%0d", k), retire, 1'b0);
      end
      iack = 1'b1;
      @(negedge clk);
      chk("iw_exec_retire", retire, 1'b0);
      @(negedge clk);
      chk("iw_retire", retire, 1'b1);
      chk("iw_pc", pc_out, 16'h0003);

      // wide, deep configuration: six pushes then an aborted load
      rst16 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cur16 = 8'hA0 | 8'(k);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc = cyc + 1;
         end while (!retire16 && cyc < 20);
         chk($sformatf("d16_retire_%0d", k), retire16, 1'b1);
      end
      for (int k = 0; k < 5; k++)
         chk($sformatf("d16_level_%0d", k), stack16[k*16 +: 16], 16'(6 - k));
      cur16 = 8'h93; dack16 = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc = cyc + 1;
      end while (!dmem_req16 && cyc < 10);
      chk("d16_req_seen", dmem_req16, 1'b1);
      @(negedge clk);
      #2 rst16 = 1'b1;
      #1;
      chk("d16_abort_req", dmem_req16, 1'b0);
      chk("d16_abort_ireq", imem_req16, 1'b0);
      chk("d16_abort_stack", stack16 == 80'h0, 1'b1);
      chk("d16_abort_pc", pc16, 16'h0000);
      chk("d16_abort_flags", flags16, 2'b00);

      chk("req_exclusive", excl_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
